// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM line.
// The line is synchronised into the clk domain, and its rising and falling
// edges drive a four-state measurement FSM. Each completed period is
// published with a one-cycle strobe. A line that stops toggling (0% or
// 100% duty) raises a sticky overflow flag.
module pwm_capture #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             ovf,
  output logic             level_out
);

  // A synchroniser shorter than two flops is not metastability-safe.
  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [STAGES-1:0] sync_q;
  logic              s;
  logic              p;
  logic              rise;
  logic              fall;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  high_lat;
  logic [CNT_W-1:0]  high_lat_nxt;
  logic [CNT_W-1:0]  period_nxt;
  logic [CNT_W-1:0]  high_nxt;
  logic              meas_valid_nxt;
  logic              ovf_nxt;

  // Synchroniser chain. It runs whenever the block is out of reset, so
  // enabling capture while the line is already high produces no rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pwm_in};
    end
  end

  assign s = sync_q[STAGES-1];

  // Previous synchronised level, used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= 1'b0;
    end else begin
      p <= s;
    end
  end

  assign rise      = s & ~p;
  assign fall      = ~s & p;
  assign level_out = s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath decisions. An edge arriving when cnt is at its
  // maximum wins over the timeout.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    high_lat_nxt   = high_lat;
    period_nxt     = period_out;
    high_nxt       = high_out;
    meas_valid_nxt = 1'b0;
    ovf_nxt        = ovf;

    if (!cap_en) begin
      // Disabling discards any measurement in progress but keeps results.
      state_nxt    = IDLE;
      cnt_nxt      = '0;
      high_lat_nxt = '0;
      ovf_nxt      = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt   = '0;
          state_nxt = WAIT_RISE;
        end

        WAIT_RISE: begin
          // The first rise only starts timing.
          if (rise) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = MEAS_HIGH;
          end
        end

        MEAS_HIGH: begin
          cnt_nxt = cnt + CNT_ONE;
          if (fall) begin
            high_lat_nxt = cnt;
            state_nxt    = MEAS_LOW;
          end else if (cnt == CNT_MAX) begin
            ovf_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT_RISE;
          end
        end

        MEAS_LOW: begin
          cnt_nxt = cnt + CNT_ONE;
          if (rise) begin
            period_nxt     = cnt;
            high_nxt       = high_lat;
            meas_valid_nxt = 1'b1;
            cnt_nxt        = CNT_ONE;
            state_nxt      = MEAS_HIGH;
          end else if (cnt == CNT_MAX) begin
            ovf_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = WAIT_RISE;
          end
        end

        default: begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Counter, latched high time, published results and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      high_lat   <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      high_lat   <= high_lat_nxt;
      period_out <= period_nxt;
      high_out   <= high_nxt;
      meas_valid <= meas_valid_nxt;
      ovf        <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture: directed scenarios plus random waveforms,
// checked by an edge-timestamp reference model and a strobe scoreboard.
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int MAXC = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         cap_en;
  logic         pwm_in;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         meas_valid;
  logic         ovf;
  logic         level_out;

  pwm_capture #(.CNT_W(W), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .cap_en     (cap_en),
    .pwm_in     (pwm_in),
    .period_out (period_out),
    .high_out   (high_out),
    .meas_valid (meas_valid),
    .ovf        (ovf),
    .level_out  (level_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int per;
    int hi;
  } exp_t;

  exp_t q[$];
  int   pushed = 0;
  int   seen   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the line as seen by the measurement engine is pwm_in
  // delayed by the synchroniser; timing is kept as edge timestamps.
  typedef enum {M_OFF, M_WAIT, M_TIME} mode_t;
  mode_t mode      = M_OFF;
  int    cyc       = 0;
  bit    hist[0:15];
  bit    started   = 0;
  int    t0        = 0;
  int    fall_age  = 0;
  int    age       = 0;
  bit    m_ovf     = 0;
  bit    m_level   = 0;
  int    m_period  = 0;
  int    m_high    = 0;
  bit    r_ev;
  bit    f_ev;

  function automatic int hidx(input int k);
    return ((k % 16) + 16) % 16;
  endfunction

  always @(posedge clk) begin
    cyc++;
    hist[hidx(cyc)] = pwm_in;
    if (rst) begin
      for (int i = 0; i <= S; i++) hist[hidx(cyc - i)] = 1'b0;
      mode     = M_OFF;
      m_ovf    = 0;
      m_period = 0;
      m_high   = 0;
      started  = 1;
    end else begin
      r_ev = hist[hidx(cyc - S)] & ~hist[hidx(cyc - S - 1)];
      f_ev = ~hist[hidx(cyc - S)] & hist[hidx(cyc - S - 1)];
      if (!cap_en) begin
        mode  = M_OFF;
        m_ovf = 0;
      end else begin
        case (mode)
          M_OFF:  mode = M_WAIT;
          M_WAIT: if (r_ev) begin
            mode = M_TIME;
            t0   = cyc;
          end
          M_TIME: begin
            age = cyc - t0;
            if (r_ev) begin
              q.push_back('{cyc, age, fall_age});
              pushed++;
              m_period = age;
              m_high   = fall_age;
              t0       = cyc;
            end else if (f_ev) begin
              fall_age = age;
            end else if (age == MAXC) begin
              m_ovf = 1;
              mode  = M_WAIT;
            end
          end
          default: mode = M_OFF;
        endcase
      end
    end
    m_level = hist[hidx(cyc - (S - 1))];
  end

  // Monitor: pops the scoreboard on every strobe and checks held outputs.
  always @(negedge clk) begin
    if (started) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_strobe: got no strobe, expected at cycle %0d (now %0d)", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (meas_valid === 1'b1) begin
        seen++;
        if (q.size() == 0 || q[0].cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL spurious_strobe: got strobe at cycle %0d, none expected", cyc);
        end else begin
          chk("strobe_period", period_out, q[0].per);
          chk("strobe_high", high_out, q[0].hi);
          void'(q.pop_front());
        end
      end
      chk("ovf", ovf, m_ovf);
      chk("level_out", level_out, m_level);
      chk("period_hold", period_out, m_period);
      chk("high_hold", high_out, m_high);
    end
  end

  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = v;
    end
  endtask

  task automatic wave(input int n, input int h, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        pwm_in = (i < h);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int h;
    int reps;
    rst    = 1'b1;
    cap_en = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_period", period_out, 0);
    chk("reset_high", high_out, 0);
    chk("reset_valid", meas_valid, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_level", level_out, 0);
    rst    = 1'b0;
    cap_en = 1'b1;

    // Steady 10/3 waveform.
    drive(1'b0, 4);
    wave(10, 3, 6);
    chk("t1_period", period_out, 10);
    chk("t1_high", high_out, 3);

    // Duty change mid-stream.
    wave(10, 3, 3);
    wave(10, 7, 4);
    chk("t2_period", period_out, 10);
    chk("t2_high", high_out, 7);

    // Stuck high: timeout, then a clean 20/5 waveform.
    drive(1'b1, 300);
    chk("t3_ovf_set", ovf, 1);
    chk("t3_level", level_out, 1);
    drive(1'b0, 5);
    wave(20, 5, 4);
    chk("t3_period", period_out, 20);
    chk("t3_high", high_out, 5);
    chk("t3_ovf_sticky", ovf, 1);

    // Enable with the line high, then disable mid low phase.
    @(negedge clk);
    cap_en = 1'b0;
    drive(1'b0, 3);
    drive(1'b1, 5);
    @(negedge clk);
    cap_en = 1'b1;
    drive(1'b1, 20);
    drive(1'b0, 6);
    drive(1'b1, 3);
    drive(1'b0, 6);
    cap_en = 1'b0;
    drive(1'b0, 3);
    drive(1'b1, 3);
    drive(1'b0, 6);
    chk("t4_ovf", ovf, 0);
    chk("t4_period_hold", period_out, 20);
    chk("t4_high_hold", high_out, 5);
    cap_en = 1'b1;
    drive(1'b0, 3);

    // Minimum waveform.
    wave(2, 1, 10);
    chk("t5_period", period_out, 2);
    chk("t5_high", high_out, 1);

    // Rise exactly at the counter maximum wins over the timeout.
    wave(MAXC, 100, 2);
    chk("max_period", period_out, MAXC);
    chk("max_high", high_out, 100);
    chk("max_no_ovf", ovf, 0);

    // Reset mid high phase.
    wave(10, 3, 3);
    drive(1'b1, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_period", period_out, 0);
    chk("t6_high", high_out, 0);
    chk("t6_valid", meas_valid, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_level", level_out, 0);
    drive(1'b1, 2);
    drive(1'b0, 5);
    wave(10, 3, 4);
    chk("t6_restart_period", period_out, 10);

    // Random waveforms with occasional disable pulses.
    for (int k = 0; k < 12; k++) begin
      n    = $urandom_range(60, 2);
      h    = $urandom_range(n - 1, 1);
      reps = $urandom_range(4, 2);
      wave(n, h, reps);
      if ($urandom_range(3, 0) == 0) begin
        @(negedge clk);
        cap_en = 1'b0;
        drive(1'b0, $urandom_range(4, 1));
        cap_en = 1'b1;
      end
    end

    drive(1'b0, 10);
    chk("queue_drained", q.size(), 0);
    chk("strobe_count", seen, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
